// File: rtl/riscv_retire_monitor.sv
// Retire monitor: turns pipeline retire events into NUM_INST, OUTPUT_PORT and a sticky HALT.
// Define RISCV_MON_CYCLE_CNT_EN to add the NUM_CYCLE cycle counter port.
module riscv_retire_monitor #(
  parameter int          CNT_W      = 32,
  parameter logic [31:0] HALT_INST0 = 32'h00c00093,
  parameter logic [31:0] HALT_INST1 = 32'h00008067
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        RET_VALID,
  input  logic [31:0] RET_INST,
  input  logic        RET_IS_BRANCH,
  input  logic        RET_BR_TAKEN,
  input  logic        RET_IS_STORE,
  input  logic [11:0] RET_ST_ADDR,
  input  logic        RET_RD_WE,
  input  logic [31:0] RET_RD_WD,
  output logic [31:0] NUM_INST,
  output logic [31:0] OUTPUT_PORT,
  output logic        HALT
`ifdef RISCV_MON_CYCLE_CNT_EN
  ,
  output logic [31:0] NUM_CYCLE
`endif
);

  localparam logic [31:0] CNT_MAX = 32'hffff_ffff >> (32 - CNT_W);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        accept_s;
  logic [31:0] num_inst_nxt_s;
  logic [31:0] output_nxt_s;

  assign accept_s = RET_VALID & ~HALT;

  // Halt-sequence detector; only accepted retires advance or disarm it
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && (RET_INST == HALT_INST0)) begin
          state_nxt_s = ST_ARMED;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (!accept_s) begin
          state_nxt_s = ST_ARMED;
        end else if (RET_INST == HALT_INST1) begin
          state_nxt_s = ST_HALTED;
        end else if (RET_INST == HALT_INST0) begin
          state_nxt_s = ST_ARMED;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HALTED: state_nxt_s = ST_HALTED;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values for the retire counter and the observable result
  always_comb begin
    num_inst_nxt_s = NUM_INST;
    output_nxt_s   = OUTPUT_PORT;
    if (accept_s) begin
      if (NUM_INST != CNT_MAX) begin
        num_inst_nxt_s = NUM_INST + 32'd1;
      end else begin
        num_inst_nxt_s = NUM_INST;
      end
      // Branch outranks store even though both together is illegal upstream
      if (RET_IS_BRANCH) begin
        output_nxt_s = {31'b0, RET_BR_TAKEN};
      end else if (RET_IS_STORE) begin
        output_nxt_s = {20'b0, RET_ST_ADDR};
      end else if (RET_RD_WE) begin
        output_nxt_s = RET_RD_WD;
      end else begin
        output_nxt_s = OUTPUT_PORT;
      end
    end else begin
      num_inst_nxt_s = NUM_INST;
      output_nxt_s   = OUTPUT_PORT;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_r     <= ST_IDLE;
      NUM_INST    <= 32'd0;
      OUTPUT_PORT <= 32'd0;
      HALT        <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      NUM_INST    <= num_inst_nxt_s;
      OUTPUT_PORT <= output_nxt_s;
      HALT        <= (state_nxt_s == ST_HALTED);
    end
  end

`ifdef RISCV_MON_CYCLE_CNT_EN
  // Cycle counter; still counts on the edge where HALT rises, then freezes
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      NUM_CYCLE <= 32'd0;
    end else if (!HALT && (NUM_CYCLE != 32'hffff_ffff)) begin
      NUM_CYCLE <= NUM_CYCLE + 32'd1;
    end else begin
      NUM_CYCLE <= NUM_CYCLE;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_retire_monitor.sv
// Directed bench for riscv_retire_monitor: a default instance and a CNT_W=8 instance share stimulus.
// NUM_CYCLE checks are compiled in when RISCV_MON_CYCLE_CNT_EN is defined.
module tb_riscv_retire_monitor;

  localparam logic [31:0] HALT0 = 32'h00c00093;
  localparam logic [31:0] HALT1 = 32'h00008067;
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [31:0] BEQ   = 32'h00000063;
  localparam logic [31:0] SW    = 32'h00102023;

  logic        clk;
  logic        rst_n;
  logic        ret_valid;
  logic [31:0] ret_inst;
  logic        ret_is_branch;
  logic        ret_br_taken;
  logic        ret_is_store;
  logic [11:0] ret_st_addr;
  logic        ret_rd_we;
  logic [31:0] ret_rd_wd;
  logic [31:0] num_inst;
  logic [31:0] output_port;
  logic        halt;
  logic [31:0] num_inst8;
  logic [31:0] output_port8;
  logic        halt8;
`ifdef RISCV_MON_CYCLE_CNT_EN
  logic [31:0] num_cycle;
  logic [31:0] num_cycle8;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  riscv_retire_monitor dut (
    .CLK(clk), .RSTn(rst_n), .RET_VALID(ret_valid), .RET_INST(ret_inst),
    .RET_IS_BRANCH(ret_is_branch), .RET_BR_TAKEN(ret_br_taken),
    .RET_IS_STORE(ret_is_store), .RET_ST_ADDR(ret_st_addr),
    .RET_RD_WE(ret_rd_we), .RET_RD_WD(ret_rd_wd),
    .NUM_INST(num_inst), .OUTPUT_PORT(output_port), .HALT(halt)
`ifdef RISCV_MON_CYCLE_CNT_EN
    , .NUM_CYCLE(num_cycle)
`endif
  );

  riscv_retire_monitor #(.CNT_W(8)) dut8 (
    .CLK(clk), .RSTn(rst_n), .RET_VALID(ret_valid), .RET_INST(ret_inst),
    .RET_IS_BRANCH(ret_is_branch), .RET_BR_TAKEN(ret_br_taken),
    .RET_IS_STORE(ret_is_store), .RET_ST_ADDR(ret_st_addr),
    .RET_RD_WE(ret_rd_we), .RET_RD_WD(ret_rd_wd),
    .NUM_INST(num_inst8), .OUTPUT_PORT(output_port8), .HALT(halt8)
`ifdef RISCV_MON_CYCLE_CNT_EN
    , .NUM_CYCLE(num_cycle8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one retire for the next rising edge; inputs change only at falling edges
  task automatic ret(input logic [31:0] inst, input logic br, input logic tk,
                     input logic st, input logic [11:0] addr,
                     input logic we, input logic [31:0] wd);
    @(negedge clk);
    ret_valid     = 1'b1;
    ret_inst      = inst;
    ret_is_branch = br;
    ret_br_taken  = tk;
    ret_is_store  = st;
    ret_st_addr   = addr;
    ret_rd_we     = we;
    ret_rd_wd     = wd;
  endtask

  task automatic idle();
    @(negedge clk);
    ret_valid     = 1'b0;
    ret_inst      = 32'd0;
    ret_is_branch = 1'b0;
    ret_br_taken  = 1'b0;
    ret_is_store  = 1'b0;
    ret_st_addr   = 12'd0;
    ret_rd_we     = 1'b0;
    ret_rd_wd     = 32'd0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    check_vec({tag, "_num"}, num_inst, 32'd0);
    check_vec({tag, "_out"}, output_port, 32'd0);
    check_vec({tag, "_halt"}, {31'd0, halt}, 32'd0);
    check_vec({tag, "_num8"}, num_inst8, 32'd0);
    check_vec({tag, "_out8"}, output_port8, 32'd0);
    check_vec({tag, "_halt8"}, {31'd0, halt8}, 32'd0);
`ifdef RISCV_MON_CYCLE_CNT_EN
    check_vec({tag, "_cyc"}, num_cycle, 32'd0);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    idle();
    check_zero("reset");
    rst_n = 1'b1;

    // addi results, back to back
    ret(NOP, 1'b0, 1'b0, 1'b0, 12'd0, 1'b1, 32'h0f00);
    idle();
    check_vec("addi_first_out", output_port, 32'h0f00);
    check_vec("addi_first_num", num_inst, 32'd1);
    ret(NOP, 1'b0, 1'b0, 1'b0, 12'd0, 1'b1, 32'h18);
    ret(NOP, 1'b0, 1'b0, 1'b0, 12'd0, 1'b1, 32'h1d);
    ret(NOP, 1'b0, 1'b0, 1'b0, 12'd0, 1'b1, 32'h1e);
    idle();
    check_vec("addi_num", num_inst, 32'd4);
    check_vec("addi_out", output_port, 32'h1e);

    // branch, store, no-writeback hold, priority cases
    ret(BEQ, 1'b1, 1'b1, 1'b0, 12'd0, 1'b0, 32'd0);
    idle();
    check_vec("br_taken_out", output_port, 32'h1);
    ret(SW, 1'b0, 1'b0, 1'b1, 12'hef0, 1'b0, 32'd0);
    idle();
    check_vec("store_out", output_port, 32'hef0);
    ret(NOP, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 32'hdead);
    idle();
    check_vec("hold_out", output_port, 32'hef0);
    check_vec("br_st_num", num_inst, 32'd7);
    ret(BEQ, 1'b1, 1'b0, 1'b1, 12'h123, 1'b1, 32'hdead);
    idle();
    check_vec("br_over_st_out", output_port, 32'h0);
    ret(SW, 1'b0, 1'b0, 1'b1, 12'h456, 1'b1, 32'hbeef);
    idle();
    check_vec("st_over_wd_out", output_port, 32'h456);
    repeat (4) idle();
    check_vec("bubble_num", num_inst, 32'd9);

    // halt with bubbles between the two words
    ret(HALT0, 1'b0, 1'b0, 1'b0, 12'd0, 1'b1, 32'd12);
    repeat (5) idle();
    check_vec("armed_halt", {31'd0, halt}, 32'd0);
    check_vec("armed_out", output_port, 32'd12);
    ret(HALT1, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 32'd0);
    idle();
    check_vec("halt_rise", {31'd0, halt}, 32'd1);
    check_vec("halt_num", num_inst, 32'd11);
    check_vec("halt_out", output_port, 32'd12);
    ret(NOP, 1'b0, 1'b0, 1'b0, 12'd0, 1'b1, 32'h55);
    ret(SW, 1'b0, 1'b0, 1'b1, 12'h777, 1'b0, 32'd0);
    idle();
    check_vec("frozen_num", num_inst, 32'd11);
    check_vec("frozen_out", output_port, 32'd12);
    check_vec("frozen_halt", {31'd0, halt}, 32'd1);

    // reset clears HALT; repeated HALT0 stays armed
    do_reset();
    check_zero("rst_halted");
    ret(HALT0, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 32'd0);
    ret(HALT0, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 32'd0);
    ret(HALT1, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 32'd0);
    idle();
    check_vec("h0h0h1_halt", {31'd0, halt}, 32'd1);
    check_vec("h0h0h1_num", num_inst, 32'd3);

    // an unrelated instruction disarms
    do_reset();
    ret(HALT0, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 32'd0);
    ret(NOP, 1'b0, 1'b0, 1'b0, 12'd0, 1'b1, 32'd0);
    ret(HALT1, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 32'd0);
    idle();
    check_vec("disarm_halt", {31'd0, halt}, 32'd0);
    check_vec("disarm_num", num_inst, 32'd3);

    // saturation of the narrow counter
    do_reset();
    for (int i = 0; i < 300; i++) begin
      ret(NOP, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 32'd0);
    end
    idle();
    check_vec("sat8_num", num_inst8, 32'h0000_00ff);
    check_vec("wide_num", num_inst, 32'd300);

    // reset while armed aborts the sequence
    ret(HALT0, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 32'd0);
    do_reset();
    check_zero("rst_armed");
    ret(HALT1, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 32'd0);
    idle();
    check_vec("lone_h1_halt", {31'd0, halt}, 32'd0);
    check_vec("lone_h1_halt8", {31'd0, halt8}, 32'd0);
    check_vec("lone_h1_num", num_inst, 32'd1);

`ifdef RISCV_MON_CYCLE_CNT_EN
    // HALT1 accepted on the 10th edge after reset release
    do_reset();
    for (int i = 0; i < 7; i++) begin
      ret(NOP, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 32'd0);
    end
    ret(HALT0, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 32'd0);
    ret(HALT1, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 32'd0);
    idle();
    check_vec("cyc_halt", {31'd0, halt}, 32'd1);
    check_vec("cyc_at_halt", num_cycle, 32'd10);
    repeat (20) idle();
    check_vec("cyc_frozen", num_cycle, 32'd10);
    check_vec("cyc_frozen8", num_cycle8, 32'd10);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
